// File: rtl/gauss_coeff_collector.sv
// Gaussian coefficient collector.
// Maps each signed sampler coefficient to its residue mod MODULUS and buffers
// the words in a small FIFO. It emits exactly one polynomial of POLY_N
// coefficients on a valid/ready stream. It also throttles the upstream random
// source through random_enable, so that words still in flight cannot overflow
// the FIFO.
module gauss_coeff_collector #(
    parameter int PARALLELISM = 4,
    parameter int VALUE_WIDTH = 13,
    parameter int COEFF_WIDTH = 12,
    parameter int MODULUS     = 3329,
    parameter int POLY_N      = 256,
    parameter int FIFO_DEPTH  = 8,
    parameter int PIPE_SLACK  = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    input  logic                                      sample_valid,
    input  logic [PARALLELISM*VALUE_WIDTH-1:0]        coeffs,
    output logic                                      random_enable,
    output logic                                      overflow,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [PARALLELISM*COEFF_WIDTH-1:0]        out_data,
    output logic [$clog2(POLY_N/PARALLELISM)-1:0]     out_index,
    output logic                                      out_last
);

    localparam int WORDS = POLY_N / PARALLELISM;
    localparam int IDX_W = $clog2(WORDS);
    localparam int ACC_W = $clog2(WORDS + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DW    = PARALLELISM * COEFF_WIDTH;
    localparam int RW    = (($clog2(MODULUS) > VALUE_WIDTH) ? $clog2(MODULUS) : VALUE_WIDTH) + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Canonical residue of a signed coefficient. |x| < MODULUS, so one
    // conditional add of the modulus is enough.
    function automatic logic [COEFF_WIDTH-1:0] to_residue(input logic signed [VALUE_WIDTH-1:0] x);
        logic signed [RW-1:0] r;
        r = {{(RW-VALUE_WIDTH){x[VALUE_WIDTH-1]}}, x};
        if (x < 0) begin
            r = r + $signed(RW'(MODULUS));
        end
        return COEFF_WIDTH'(r);
    endfunction

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              ovf_q, ovf_d;
    logic              ren_q, ren_d;
    logic              push, pop;
    logic [DW-1:0]     wr_word;
    logic [DW-1:0]     mem_q [FIFO_DEPTH];

    // Lane-wise conversion of the incoming word ahead of the FIFO write.
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            wr_word[COEFF_WIDTH*i +: COEFF_WIDTH] = to_residue(coeffs[VALUE_WIDTH*i +: VALUE_WIDTH]);
        end
    end

    // Next-state logic for the FSM, the counters, the FIFO pointers and the throttle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        pop      = (cnt_q != '0) && out_ready;

        if (pop) begin
            idx_d = (idx_q == IDX_W'(WORDS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (sample_valid) begin
                    if ((cnt_q < CNT_W'(FIFO_DEPTH)) || pop) begin
                        push = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (push) begin
                    acc_d = acc_q + ACC_W'(1);
                end
                if (acc_d == ACC_W'(WORDS)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (idx_q == IDX_W'(WORDS - 1))) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        // Keep enough headroom for PIPE_SLACK in-flight words, and do not ask
        // for more words than the polynomial still needs.
        ren_d = (state_d == S_RUN)
             && ((CNT_W'(FIFO_DEPTH) - cnt_d) > CNT_W'(PIPE_SLACK))
             && (({1'b0, acc_d} + (ACC_W+1)'(cnt_d)) < (ACC_W+1)'(WORDS));
    end

    // Control registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            ren_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            ren_q    <= ren_d;
        end
    end

    // FIFO storage. The storage is not reset; the occupancy count qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign random_enable = ren_q;
    assign overflow      = ovf_q;
    assign out_valid     = (cnt_q != '0);
    assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_index     = idx_q;
    assign out_last      = out_valid && (idx_q == IDX_W'(WORDS - 1));

endmodule

// File: tb/tb_gauss_coeff_collector.sv
// Directed bench for gauss_coeff_collector: stream contents, throttling,
// overflow, idle and restart filtering, and mid-run reset.
module tb_gauss_coeff_collector;

    logic        clk = 1'b0;
    logic        rst, start, sample_valid, out_ready;
    logic [51:0] coeffs;
    logic        busy, done, random_enable, overflow, out_valid, out_last;
    logic [47:0] out_data;
    logic [5:0]  out_index;

    always #5 clk = ~clk;

    gauss_coeff_collector #(
        .PARALLELISM(4), .VALUE_WIDTH(13), .COEFF_WIDTH(12), .MODULUS(3329),
        .POLY_N(256), .FIFO_DEPTH(8), .PIPE_SLACK(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sample_valid(sample_valid), .coeffs(coeffs), .random_enable(random_enable),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last)
    );

    int          errors = 0;
    int          checks = 0;
    logic [47:0] exp_q[$];
    logic [47:0] cur_exp;
    int          exp_idx = 0;
    int          hs_count = 0;
    int          n_acc = 0;
    logic [3:0]  pipe = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int res(input int x);
        return (x < 0) ? 3329 + x : x;
    endfunction

    task automatic set_word(input int a, input int b, input int c, input int d);
        coeffs  = {13'(d), 13'(c), 13'(b), 13'(a)};
        cur_exp = {12'(res(d)), 12'(res(c)), 12'(res(b)), 12'(res(a))};
    endtask

    task automatic set_k(input int k);
        set_word(-(k + 1), 3 * k, -11 * k, 3000 - k);
    endtask

    // Advance one clock; check any handshake taking place at this edge.
    task automatic tick();
        logic        hs, lst;
        logic [47:0] e;
        hs  = out_valid && out_ready;
        lst = hs && out_last;
        if (hs) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL stream_extra: observed word %0h expected none", out_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
            end
            chk("out_index", out_index, exp_idx);
            chk("out_last", out_last, exp_idx == 63);
            exp_idx = (exp_idx + 1) % 64;
            hs_count++;
        end
        @(posedge clk);
        #1;
        if (lst) begin
            chk("done_pulse", done, 1);
            chk("busy_at_done", busy, 0);
        end
    endtask

    task automatic send(input bit accept);
        sample_valid = 1'b1;
        if (accept) exp_q.push_back(cur_exp);
        tick();
    endtask

    // Upstream source with 4-cycle latency from random_enable to sample_valid.
    task automatic up_step();
        sample_valid = pipe[3];
        pipe = {pipe[2:0], random_enable};
        if (sample_valid) begin
            if (n_acc == 0) set_word(-1, -15, 0, 7);
            else set_k(n_acc);
            if (n_acc < 64) begin
                exp_q.push_back(cur_exp);
                n_acc++;
            end
        end
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_idx = 0;
        hs_count = 0;
        n_acc = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input bit upstream);
        int n;
        n = 0;
        while (!done && n < 1500) begin
            if (upstream) up_step();
            else tick();
            n++;
        end
        sample_valid = 1'b0;
        pipe = '0;
        chk("done_seen", done, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("handshakes", hs_count, 64);
    endtask

    task automatic chk_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", random_enable, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sample_valid = 1'b0; out_ready = 1'b0; coeffs = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset();
        rst = 1'b0;

        // Poly 1: zero coefficients, consumer always ready.
        out_ready = 1'b1;
        do_start();
        chk("ren_after_start", random_enable, 1);
        for (int k = 0; k < 64; k++) begin
            set_word(0, 0, 0, 0);
            send(1'b1);
        end
        sample_valid = 1'b0;
        wait_done(1'b0);
        chk("p1_overflow", overflow, 0);

        // Poly 2: consumer stalled, throttled upstream fills the FIFO safely.
        out_ready = 1'b0;
        do_start();
        for (int c = 0; c < 30; c++) up_step();
        chk("throttle_words", n_acc, 8);
        chk("throttle_ren", random_enable, 0);
        chk("throttle_ovf", overflow, 0);
        chk("throttle_valid", out_valid, 1);
        chk("lane_conv", out_data, {12'd7, 12'd0, 12'd3314, 12'd3328});
        up_step();
        up_step();
        chk("hold_data", out_data, {12'd7, 12'd0, 12'd3314, 12'd3328});
        chk("hold_index", out_index, 0);
        out_ready = 1'b1;
        wait_done(1'b1);
        chk("p2_overflow", overflow, 0);

        // Inputs while idle are discarded.
        set_k(5);
        sample_valid = 1'b1;
        tick(); tick(); tick();
        sample_valid = 1'b0;
        chk("idle_valid", out_valid, 0);
        chk("idle_ovf", overflow, 0);
        chk("idle_busy", busy, 0);

        // Poly 3: nine forced words into a stalled FIFO; the ninth is dropped.
        out_ready = 1'b0;
        do_start();
        for (int k = 0; k < 9; k++) begin
            set_k(k);
            send(k < 8);
        end
        sample_valid = 1'b0;
        tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_ren", random_enable, 0);
        chk("ovf_busy", busy, 1);
        out_ready = 1'b1;
        for (int k = 9; k < 65; k++) begin
            set_k(k);
            if (k == 30) start = 1'b1;
            send(1'b1);
            start = 1'b0;
        end
        sample_valid = 1'b0;
        chk("restart_ignored_busy", busy, 1);
        wait_done(1'b0);
        chk("ovf_sticky", overflow, 1);

        // Poly 4: reset after 30 accepted words, then a clean full run.
        out_ready = 1'b1;
        do_start();
        chk("ovf_cleared", overflow, 0);
        for (int k = 0; k < 30; k++) begin
            set_k(k);
            send(1'b1);
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset();
        rst = 1'b0;
        exp_q.delete();
        exp_idx = 0;
        tick();
        do_start();
        for (int k = 0; k < 64; k++) begin
            set_k(k + 40);
            send(1'b1);
        end
        sample_valid = 1'b0;
        wait_done(1'b0);
        chk("p4_overflow", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
